dart_uart_rx: RTL and testbench



---
 rtl/dart_uart_pkg.sv | 26 ++
 rtl/dart_uart_rx_byte.sv | 107 ++++++++++
 rtl/dart_uart_rx.sv | 89 ++++++++
 tb/tb_dart_uart_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dart_uart_pkg.sv
// Shared types and sizing helpers for the DART UART receive path.
package dart_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned calc_half(input int unsigned div);
    return div / 2;
  endfunction

  // Bits needed for a counter spanning 0 .. max_count-1.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/dart_uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit timer and frame FSM.
// Strobes are combinational and valid in the cycle of the stop-bit sample.
module dart_uart_rx_byte
  import dart_uart_pkg::*;
#(
  parameter int unsigned DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_line,
  output logic [7:0] byte_data,
  output logic       byte_valid_c,
  output logic       frame_err_c,
  output logic       start_det_c,
  output logic       idle_c
);

  localparam int unsigned HALF = calc_half(DIV);
  localparam int unsigned TW   = cnt_width(DIV);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [TW-1:0] timer_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          timer_zero;
  logic          load_half, load_div, shift_en, clr_bitcnt;

  assign rxs        = sync_q[1];
  assign timer_zero = (timer_q == '0);
  assign byte_data  = shift_q;

  // Two-flop synchroniser, idle-high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_line};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable && !rxs) state_d = START;
      START:     if (timer_zero) state_d = rxs ? IDLE : DATA;
      DATA:      if (timer_zero && bitcnt_q == 3'd7) state_d = STOP;
      STOP:      if (timer_zero) state_d = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    load_half    = 1'b0;
    load_div     = 1'b0;
    shift_en     = 1'b0;
    clr_bitcnt   = 1'b0;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    start_det_c  = 1'b0;
    idle_c       = 1'b0;
    case (state_q)
      IDLE: begin
        idle_c      = 1'b1;
        start_det_c = enable && !rxs;
        load_half   = enable && !rxs;
      end
      START: begin
        load_div   = timer_zero && !rxs;
        clr_bitcnt = timer_zero && !rxs;
      end
      DATA: begin
        load_div = timer_zero;
        shift_en = timer_zero;
      end
      STOP: begin
        byte_valid_c = timer_zero && rxs;
        frame_err_c  = timer_zero && !rxs;
      end
      default: ;
    endcase
  end

  // Bit timer counts down to the next sample point; data shifts in LSB-first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      if (load_half)       timer_q <= TW'(HALF - 1);
      else if (load_div)   timer_q <= TW'(DIV - 1);
      else if (!timer_zero) timer_q <= timer_q - TW'(1);

      if (clr_bitcnt) bitcnt_q <= '0;
      else if (shift_en) bitcnt_q <= bitcnt_q + 3'd1;

      if (shift_en) shift_q <= {rxs, shift_q[7:1]};
    end
  end

endmodule

// File: rtl/dart_uart_rx.sv
// DART UART receive front end: packs BYTES received bytes (first byte in the
// MSBs) into one word, with sticky framing / inter-byte-timeout error flag.
module dart_uart_rx
  import dart_uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             RS232_RX_DATA,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_error
);

  localparam int unsigned DIV      = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned BYTES    = WIDTH / 8;
  localparam int unsigned BCW      = cnt_width(BYTES);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * DIV;
  localparam int unsigned TOW      = cnt_width(TO_LIMIT);

  logic [7:0]       byte_data;
  logic             byte_valid_c, frame_err_c, start_det_c, idle_c;
  logic [BCW-1:0]   bytecnt_q;
  logic [WIDTH-1:0] word_q, word_next;
  logic [TOW-1:0]   to_cnt_q;
  logic             to_run_c, timeout_c;

  dart_uart_rx_byte #(
    .DIV (DIV)
  ) u_byte (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rx_line      (RS232_RX_DATA),
    .byte_data    (byte_data),
    .byte_valid_c (byte_valid_c),
    .frame_err_c  (frame_err_c),
    .start_det_c  (start_det_c),
    .idle_c       (idle_c)
  );

  assign word_next = (word_q << 8) | WIDTH'(byte_data);
  assign to_run_c  = idle_c && (bytecnt_q != '0);
  // A start edge in the same cycle as expiry wins over the timeout
  assign timeout_c = to_run_c && !start_det_c && (to_cnt_q == TOW'(TO_LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (start_det_c || !to_run_c || timeout_c) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TOW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bytecnt_q <= '0;
      word_q    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (byte_valid_c) begin
        if (bytecnt_q == BCW'(BYTES - 1)) begin
          rx_data   <= word_next;
          rx_valid  <= 1'b1;
          bytecnt_q <= '0;
          word_q    <= '0;
        end else begin
          word_q    <= word_next;
          bytecnt_q <= bytecnt_q + BCW'(1);
        end
      end else if (frame_err_c || timeout_c) begin
        bytecnt_q <= '0;
        word_q    <= '0;
        rx_error  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dart_uart_rx.sv
// Self-checking bench for dart_uart_rx at DIV=16, WIDTH=16, TIMEOUT_BITS=32.
module tb_dart_uart_rx;
  import dart_uart_pkg::*;

  localparam int unsigned BIT = 16;
  localparam int unsigned HALF = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        line = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_error;

  int          tests_run = 0;
  int          failed = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          last_strobe_cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  dart_uart_rx #(
    .CLOCK_FREQ   (160),
    .BAUD_RATE    (10),
    .WIDTH        (16),
    .TIMEOUT_BITS (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .RS232_RX_DATA (line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_error      (rx_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every strobe for the scoreboard
  always @(negedge clock) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      strobes <= strobes + 1;
      last_strobe_cyc <= cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d strobes, required completion", strobes);
    $fatal(1, "watchdog");
  end

  // Must be called on a falling edge; ends on a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    line = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      repeat (BIT) @(negedge clock);
    end
    line = stop_bit;
    repeat (BIT) @(negedge clock);
    line = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset;
    idle(3);
    tests_run++;
    if (rx_data !== 16'h0000 || rx_valid !== 1'b0 || rx_error !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got data=%h valid=%b err=%b, required 0000/0/0", rx_data, rx_valid, rx_error);
    end
    reset = 1'b0;
    idle(4);
  endtask

  task automatic test_back_to_back;
    int c0, s0;
    logic [15:0] w;
    s0 = strobes;
    c0 = cyc;
    exp_q.push_back(16'hA53C);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    wait_got(1, 200);
    tests_run++;
    if (got_q.size() == 0) begin
      failed++;
      $display("FAIL b2b_word: got no strobe, required %h", exp_q.pop_front());
    end else begin
      w = got_q.pop_front();
      if (w !== exp_q[0]) begin
        failed++;
        $display("FAIL b2b_word: got %h, required %h", w, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    tests_run++;
    if (last_strobe_cyc - c0 !== 315) begin
      failed++;
      $display("FAIL b2b_latency: got %0d cycles, required 315", last_strobe_cyc - c0);
    end
    tests_run++;
    if (strobes - s0 !== 1) begin
      failed++;
      $display("FAIL b2b_count: got %0d strobes, required 1", strobes - s0);
    end
    tests_run++;
    if (rx_error !== 1'b0) begin
      failed++;
      $display("FAIL b2b_error: got %b, required 0", rx_error);
    end
  endtask

  task automatic test_glitch;
    int s0;
    s0 = strobes;
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(HALF + 4);
    tests_run++;
    if (dut.u_byte.state_q !== IDLE) begin
      failed++;
      $display("FAIL glitch_state: got %0d, required IDLE", dut.u_byte.state_q);
    end
    idle(200);
    tests_run++;
    if (strobes !== s0 || rx_error !== 1'b0) begin
      failed++;
      $display("FAIL glitch_quiet: got strobes+%0d err=%b, required +0 err=0", strobes - s0, rx_error);
    end
  endtask

  task automatic test_enable;
    int s0;
    logic [15:0] w;
    s0 = strobes;
    enable = 1'b0;
    send_byte(8'hA5, 1'b1);
    idle(2 * BIT);
    enable = 1'b1;
    idle(2);
    tests_run++;
    if (strobes !== s0 || dut.u_byte.state_q !== IDLE) begin
      failed++;
      $display("FAIL enable_ignore: got strobes+%0d state=%0d, required +0 IDLE", strobes - s0, dut.u_byte.state_q);
    end
    exp_q.push_back(16'h1234);
    fork
      send_byte(8'h12, 1'b1);
      begin
        idle(40);
        enable = 1'b0;
        idle(80);
        enable = 1'b1;
      end
    join
    send_byte(8'h34, 1'b1);
    wait_got(1, 200);
    tests_run++;
    if (got_q.size() == 0) begin
      failed++;
      $display("FAIL enable_word: got no strobe, required %h", exp_q.pop_front());
    end else begin
      w = got_q.pop_front();
      if (w !== exp_q[0]) begin
        failed++;
        $display("FAIL enable_word: got %h, required %h", w, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_framing;
    int s0;
    logic [15:0] w;
    s0 = strobes;
    send_byte(8'h77, 1'b0);
    line = 1'b0;
    idle(24);
    line = 1'b1;
    idle(2 * BIT);
    tests_run++;
    if (rx_error !== 1'b1 || strobes !== s0) begin
      failed++;
      $display("FAIL framing_flag: got err=%b strobes+%0d, required err=1 +0", rx_error, strobes - s0);
    end
    exp_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_got(1, 200);
    tests_run++;
    if (got_q.size() == 0) begin
      failed++;
      $display("FAIL framing_word: got no strobe, required %h", exp_q.pop_front());
    end else begin
      w = got_q.pop_front();
      if (w !== exp_q[0]) begin
        failed++;
        $display("FAIL framing_word: got %h, required %h", w, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    logic [15:0] w;
    b = 8'hA5;
    line = 1'b0;
    idle(BIT);
    for (int i = 0; i < 3; i++) begin
      line = b[i];
      idle(BIT);
    end
    line = b[3];
    idle(HALF);
    reset = 1'b1;
    #1;
    tests_run++;
    if (rx_data !== 16'h0000 || rx_valid !== 1'b0 || rx_error !== 1'b0) begin
      failed++;
      $display("FAIL midreset_outputs: got data=%h valid=%b err=%b, required 0000/0/0", rx_data, rx_valid, rx_error);
    end
    @(negedge clock);
    line = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2 * BIT);
    exp_q.push_back(16'hBEEF);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    wait_got(1, 200);
    tests_run++;
    if (got_q.size() == 0) begin
      failed++;
      $display("FAIL midreset_word: got no strobe, required %h", exp_q.pop_front());
    end else begin
      w = got_q.pop_front();
      if (w !== exp_q[0]) begin
        failed++;
        $display("FAIL midreset_word: got %h, required %h", w, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_timeout;
    logic [15:0] w;
    send_byte(8'h55, 1'b1);
    idle(490);
    tests_run++;
    if (rx_error !== 1'b0) begin
      failed++;
      $display("FAIL timeout_early: got err=%b, required 0", rx_error);
    end
    idle(32 * BIT + 4 - 490);
    tests_run++;
    if (rx_error !== 1'b1) begin
      failed++;
      $display("FAIL timeout_flag: got err=%b, required 1", rx_error);
    end
    exp_q.push_back(16'h00FF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_got(1, 200);
    tests_run++;
    if (got_q.size() == 0) begin
      failed++;
      $display("FAIL timeout_word: got no strobe, required %h", exp_q.pop_front());
    end else begin
      w = got_q.pop_front();
      if (w !== exp_q[0]) begin
        failed++;
        $display("FAIL timeout_word: got %h, required %h", w, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    idle(100);
    tests_run++;
    if (got_q.size() != 0) begin
      failed++;
      $display("FAIL extra_strobes: got %0d unexpected words, required 0", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_glitch();
    test_enable();
    test_framing();
    test_reset_mid_frame();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
